// File: rtl/dlx_ctrl_pipe.sv
// rtl/dlx_ctrl_pipe.sv - DLX control pipeline registers and interlock; optional forwarding under CTRL_PIPE_FWD_EN
module dlx_ctrl_pipe #(
  parameter int FPU_LAT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [0:24] id_ctrl,
  input  logic [0:4]  id_rs1,
  input  logic [0:4]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [0:4]  id_rd,
  input  logic        ex_flush,
  output logic        id_stall,
  output logic        ex_valid,
  output logic [0:24] ex_ctrl,
  output logic        ex_fpu_done,
  output logic        mem_valid,
  output logic [0:1]  mem_size,
  output logic        mem_we,
  output logic        mem_ext,
  output logic        wb_valid,
  output logic [0:1]  wb_din_src,
  output logic [0:4]  wb_rd,
  output logic        wb_gpr_we,
  output logic        wb_fpr_we,
  output logic [0:1]  fwd_a,
  output logic [0:1]  fwd_b
);

  localparam logic [0:1] DIN_FPU  = 2'b10;
  localparam logic [0:1] DIN_LOAD = 2'b11;
  localparam logic [3:0] FPU_LOAD = 4'(FPU_LAT - 1);

  // ID/EX stage
  logic        ex_valid_q, ex_valid_d;
  logic [0:24] ex_ctrl_q, ex_ctrl_d;
  logic [0:4]  ex_rd_q, ex_rd_d;
  logic [3:0]  fpu_cnt_q, fpu_cnt_d;

  // EX/MEM stage keeps only the fields MEM and WB still need
  logic        mem_valid_q, mem_valid_d;
  logic [0:1]  mem_din_q, mem_din_d;
  logic        mem_regwe_q, mem_regwe_d;
  logic        mem_fpd_q, mem_fpd_d;
  logic [0:1]  mem_size_q, mem_size_d;
  logic        mem_we_q, mem_we_d;
  logic        mem_ext_q, mem_ext_d;
  logic [0:4]  mem_rd_q, mem_rd_d;

  // MEM/WB stage
  logic        wb_valid_q, wb_valid_d;
  logic [0:1]  wb_din_q, wb_din_d;
  logic        wb_regwe_q, wb_regwe_d;
  logic        wb_fpd_q, wb_fpd_d;
  logic [0:4]  wb_rd_q, wb_rd_d;

  logic hold, id_fp, ex_dst_we, mem_dst_we, wb_dst_we;
  logic rs1_ex, rs2_ex, hazard, load_id;

  // Register-file match: same index, same file, and r0 never aliases in the GPR file
  function automatic logic dst_match(input logic [0:4] src, input logic src_fp,
                                     input logic dst_we, input logic dst_fp,
                                     input logic [0:4] dst);
    return dst_we && (dst_fp == src_fp) && (dst == src) && (src_fp || (src != 5'd0));
  endfunction

  assign hold       = (fpu_cnt_q != 4'd0);
  assign id_fp      = id_ctrl[10];
  assign ex_dst_we  = ex_valid_q & ex_ctrl_q[2];
  assign mem_dst_we = mem_valid_q & mem_regwe_q;
  assign wb_dst_we  = wb_valid_q & wb_regwe_q;
  assign rs1_ex     = id_use_rs1 & dst_match(id_rs1, id_fp, ex_dst_we, ex_ctrl_q[3], ex_rd_q);
  assign rs2_ex     = id_use_rs2 & dst_match(id_rs2, id_fp, ex_dst_we, ex_ctrl_q[3], ex_rd_q);

`ifdef CTRL_PIPE_FWD_EN
  logic [0:4] ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d;
  logic       ex_use1_q, ex_use1_d, ex_use2_q, ex_use2_d;

  // With forwarding only a load in EX (data not yet read) or a busy FPU forces a stall
  assign hazard = id_valid & (rs1_ex | rs2_ex) &
                  ((ex_ctrl_q[0:1] == DIN_LOAD) | ((ex_ctrl_q[0:1] == DIN_FPU) & hold));

  // EX/MEM result has priority over the older MEM/WB result
  assign fwd_a = !ex_use1_q ? 2'b00 :
                 dst_match(ex_rs1_q, ex_ctrl_q[10], mem_dst_we, mem_fpd_q, mem_rd_q) ? 2'b01 :
                 dst_match(ex_rs1_q, ex_ctrl_q[10], wb_dst_we, wb_fpd_q, wb_rd_q)    ? 2'b10 : 2'b00;
  assign fwd_b = !ex_use2_q ? 2'b00 :
                 dst_match(ex_rs2_q, ex_ctrl_q[10], mem_dst_we, mem_fpd_q, mem_rd_q) ? 2'b01 :
                 dst_match(ex_rs2_q, ex_ctrl_q[10], wb_dst_we, wb_fpd_q, wb_rd_q)    ? 2'b10 : 2'b00;

  // Source indices follow the ID/EX word: held, loaded, or cleared with a bubble
  always_comb begin
    ex_rs1_d  = ex_rs1_q;
    ex_rs2_d  = ex_rs2_q;
    ex_use1_d = ex_use1_q;
    ex_use2_d = ex_use2_q;
    if (!hold) begin
      ex_rs1_d  = load_id ? id_rs1 : 5'd0;
      ex_rs2_d  = load_id ? id_rs2 : 5'd0;
      ex_use1_d = load_id & id_use_rs1;
      ex_use2_d = load_id & id_use_rs2;
    end
  end

  // Source index registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_rs1_q  <= '0;
      ex_rs2_q  <= '0;
      ex_use1_q <= 1'b0;
      ex_use2_q <= 1'b0;
    end else begin
      ex_rs1_q  <= ex_rs1_d;
      ex_rs2_q  <= ex_rs2_d;
      ex_use1_q <= ex_use1_d;
      ex_use2_q <= ex_use2_d;
    end
  end
`else
  logic rs1_mem, rs2_mem;

  // Without forwarding any producer still in EX or MEM blocks the reader
  assign rs1_mem = id_use_rs1 & dst_match(id_rs1, id_fp, mem_dst_we, mem_fpd_q, mem_rd_q);
  assign rs2_mem = id_use_rs2 & dst_match(id_rs2, id_fp, mem_dst_we, mem_fpd_q, mem_rd_q);
  assign hazard  = id_valid & (rs1_ex | rs2_ex | rs1_mem | rs2_mem);
  assign fwd_a   = 2'b00;
  assign fwd_b   = 2'b00;
`endif

  assign load_id  = id_valid & ~hazard & ~ex_flush;
  assign id_stall = hold | (hazard & ~ex_flush);

  // Next state: FPU hold freezes EX and bubbles MEM, otherwise ID/EX takes an instruction or a bubble
  always_comb begin
    ex_valid_d  = ex_valid_q;
    ex_ctrl_d   = ex_ctrl_q;
    ex_rd_d     = ex_rd_q;
    fpu_cnt_d   = fpu_cnt_q;
    mem_valid_d = ex_valid_q;
    mem_din_d   = ex_ctrl_q[0:1];
    mem_regwe_d = ex_ctrl_q[2];
    mem_fpd_d   = ex_ctrl_q[3];
    mem_size_d  = ex_ctrl_q[21:22];
    mem_we_d    = ex_ctrl_q[23];
    mem_ext_d   = ex_ctrl_q[24];
    mem_rd_d    = ex_rd_q;
    wb_valid_d  = mem_valid_q;
    wb_din_d    = mem_din_q;
    wb_regwe_d  = mem_regwe_q;
    wb_fpd_d    = mem_fpd_q;
    wb_rd_d     = mem_rd_q;
    if (hold) begin
      fpu_cnt_d   = fpu_cnt_q - 4'd1;
      mem_valid_d = 1'b0;
      mem_din_d   = 2'b00;
      mem_regwe_d = 1'b0;
      mem_fpd_d   = 1'b0;
      mem_size_d  = 2'b00;
      mem_we_d    = 1'b0;
      mem_ext_d   = 1'b0;
      mem_rd_d    = 5'd0;
    end else if (load_id) begin
      ex_valid_d = 1'b1;
      ex_ctrl_d  = id_ctrl;
      ex_rd_d    = id_rd;
      fpu_cnt_d  = (id_ctrl[0:1] == DIN_FPU) ? FPU_LOAD : 4'd0;
    end else begin
      ex_valid_d = 1'b0;
      ex_ctrl_d  = '0;
      ex_rd_d    = 5'd0;
      fpu_cnt_d  = 4'd0;
    end
  end

  // Pipeline registers; reset abandons any FPU countdown
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q  <= 1'b0;
      ex_ctrl_q   <= '0;
      ex_rd_q     <= '0;
      fpu_cnt_q   <= '0;
      mem_valid_q <= 1'b0;
      mem_din_q   <= '0;
      mem_regwe_q <= 1'b0;
      mem_fpd_q   <= 1'b0;
      mem_size_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_ext_q   <= 1'b0;
      mem_rd_q    <= '0;
      wb_valid_q  <= 1'b0;
      wb_din_q    <= '0;
      wb_regwe_q  <= 1'b0;
      wb_fpd_q    <= 1'b0;
      wb_rd_q     <= '0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_ctrl_q   <= ex_ctrl_d;
      ex_rd_q     <= ex_rd_d;
      fpu_cnt_q   <= fpu_cnt_d;
      mem_valid_q <= mem_valid_d;
      mem_din_q   <= mem_din_d;
      mem_regwe_q <= mem_regwe_d;
      mem_fpd_q   <= mem_fpd_d;
      mem_size_q  <= mem_size_d;
      mem_we_q    <= mem_we_d;
      mem_ext_q   <= mem_ext_d;
      mem_rd_q    <= mem_rd_d;
      wb_valid_q  <= wb_valid_d;
      wb_din_q    <= wb_din_d;
      wb_regwe_q  <= wb_regwe_d;
      wb_fpd_q    <= wb_fpd_d;
      wb_rd_q     <= wb_rd_d;
    end
  end

  assign ex_valid    = ex_valid_q;
  assign ex_ctrl     = ex_ctrl_q;
  assign ex_fpu_done = ~hold & ex_valid_q & (ex_ctrl_q[0:1] == DIN_FPU);
  assign mem_valid   = mem_valid_q;
  assign mem_size    = mem_size_q;
  assign mem_we      = mem_we_q & mem_valid_q;
  assign mem_ext     = mem_ext_q;
  assign wb_valid    = wb_valid_q;
  assign wb_din_src  = wb_din_q;
  assign wb_rd       = wb_rd_q;
  assign wb_gpr_we   = wb_regwe_q & ~wb_fpd_q & wb_valid_q & (wb_rd_q != 5'd0);
  assign wb_fpr_we   = wb_regwe_q & wb_fpd_q & wb_valid_q;

endmodule

// File: tb/tb_dlx_ctrl_pipe.sv
// tb/tb_dlx_ctrl_pipe.sv - randomized and directed check of dlx_ctrl_pipe against a stage-record model
module tb_dlx_ctrl_pipe;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [0:24] id_ctrl;
  logic [0:4]  id_rs1, id_rs2, id_rd;
  logic        id_use_rs1, id_use_rs2, ex_flush;
  logic        id_stall, ex_valid, ex_fpu_done, mem_valid, mem_we, mem_ext;
  logic [0:24] ex_ctrl;
  logic [0:1]  mem_size, wb_din_src, fwd_a, fwd_b;
  logic        wb_valid, wb_gpr_we, wb_fpr_we;
  logic [0:4]  wb_rd;

  dlx_ctrl_pipe #(.FPU_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ctrl(id_ctrl),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .ex_flush(ex_flush), .id_stall(id_stall), .ex_valid(ex_valid),
    .ex_ctrl(ex_ctrl), .ex_fpu_done(ex_fpu_done), .mem_valid(mem_valid),
    .mem_size(mem_size), .mem_we(mem_we), .mem_ext(mem_ext), .wb_valid(wb_valid),
    .wb_din_src(wb_din_src), .wb_rd(wb_rd), .wb_gpr_we(wb_gpr_we), .wb_fpr_we(wb_fpr_we),
    .fwd_a(fwd_a), .fwd_b(fwd_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [0:24] c;
    logic [0:4]  rd, rs1, rs2;
    logic        u1, u2;
  } ins_t;

  ins_t m_ex, m_mem, m_wb;
  int   m_left;
  int   total = 0;
  int   bad = 0;
  bit   rst_req;

  function automatic ins_t bubble();
    ins_t b;
    b.v = 1'b0; b.c = '0; b.rd = '0; b.rs1 = '0; b.rs2 = '0; b.u1 = 1'b0; b.u2 = 1'b0;
    return b;
  endfunction

  function automatic logic [0:24] mk(input logic [1:0] din, input logic we, input logic fpd, input logic fps);
    logic [0:24] c;
    c = '0;
    c[0:1] = din;
    c[2] = we;
    c[3] = fpd;
    c[10] = fps;
    return c;
  endfunction

  function automatic ins_t op(input logic [0:24] c, input int rd, input int s1, input int s2,
                              input bit u1, input bit u2);
    ins_t r;
    r.v = 1'b1; r.c = c; r.rd = 5'(rd); r.rs1 = 5'(s1); r.rs2 = 5'(s2); r.u1 = u1; r.u2 = u2;
    return r;
  endfunction

  function automatic ins_t rnd();
    ins_t r;
    logic [24:0] t;
    t = 25'($urandom);
    r.v = ($urandom_range(0, 3) != 0);
    r.c = t;
    r.rd = 5'($urandom_range(0, 3));
    r.rs1 = 5'($urandom_range(0, 3));
    r.rs2 = 5'($urandom_range(0, 3));
    r.u1 = 1'($urandom);
    r.u2 = 1'($urandom);
    return r;
  endfunction

  // Does stage s write register idx of the given file?
  function automatic bit writes(input ins_t s, input logic [0:4] idx, input bit fp);
    return s.v && s.c[2] && (s.c[3] == fp) && (s.rd == idx) && (fp || idx != 0);
  endfunction

  function automatic bit src_blocked(input logic [0:4] idx, input bit fp);
`ifdef CTRL_PIPE_FWD_EN
    return writes(m_ex, idx, fp) && (m_ex.c[0:1] == 2'b11 || (m_ex.c[0:1] == 2'b10 && m_left > 0));
`else
    return writes(m_ex, idx, fp) || writes(m_mem, idx, fp);
`endif
  endfunction

  function automatic bit m_hazard(input ins_t i);
    if (!i.v) return 1'b0;
    return (i.u1 && src_blocked(i.rs1, i.c[10])) || (i.u2 && src_blocked(i.rs2, i.c[10]));
  endfunction

  function automatic logic [1:0] fsel(input logic [0:4] idx, input bit use_src);
`ifdef CTRL_PIPE_FWD_EN
    if (!use_src) return 2'd0;
    if (writes(m_mem, idx, m_ex.c[10])) return 2'd1;
    if (writes(m_wb, idx, m_ex.c[10])) return 2'd2;
    return 2'd0;
`else
    return (use_src && idx == 5'd31) ? 2'd0 : 2'd0;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ex = bubble(); m_mem = bubble(); m_wb = bubble(); m_left = 0;
  endtask

  task automatic check_all(input ins_t i, input bit fl);
    bit hold;
    hold = (m_left > 0);
    chk("id_stall", 32'(id_stall), 32'(hold || (m_hazard(i) && !fl)));
    chk("ex_valid", 32'(ex_valid), 32'(m_ex.v));
    chk("ex_ctrl", 32'(ex_ctrl), 32'(m_ex.c));
    chk("ex_fpu_done", 32'(ex_fpu_done), 32'(!hold && m_ex.v && m_ex.c[0:1] == 2'b10));
    chk("mem_valid", 32'(mem_valid), 32'(m_mem.v));
    chk("mem_size", 32'(mem_size), 32'(m_mem.c[21:22]));
    chk("mem_we", 32'(mem_we), 32'(m_mem.c[23] && m_mem.v));
    chk("mem_ext", 32'(mem_ext), 32'(m_mem.c[24]));
    chk("wb_valid", 32'(wb_valid), 32'(m_wb.v));
    chk("wb_din_src", 32'(wb_din_src), 32'(m_wb.c[0:1]));
    chk("wb_rd", 32'(wb_rd), 32'(m_wb.rd));
    chk("wb_gpr_we", 32'(wb_gpr_we), 32'(m_wb.v && m_wb.c[2] && !m_wb.c[3] && m_wb.rd != 0));
    chk("wb_fpr_we", 32'(wb_fpr_we), 32'(m_wb.v && m_wb.c[2] && m_wb.c[3]));
    chk("fwd_a", 32'(fwd_a), 32'(fsel(m_ex.rs1, m_ex.u1)));
    chk("fwd_b", 32'(fwd_b), 32'(fsel(m_ex.rs2, m_ex.u2)));
  endtask

  task automatic advance(input ins_t i, input bit fl);
    bit haz;
    if (!rst_n) begin
      model_reset();
      return;
    end
    haz = m_hazard(i);
    m_wb = m_mem;
    if (m_left > 0) begin
      m_mem = bubble();
      m_left--;
    end else begin
      m_mem = m_ex;
      if (fl || haz || !i.v) begin
        m_ex = bubble();
        m_left = 0;
      end else begin
        m_ex = i;
        m_left = (i.c[0:1] == 2'b10) ? LAT - 1 : 0;
      end
    end
  endtask

  // One cycle: drive at the falling edge, check just after, then step the model for the coming edge
  task automatic cyc(input ins_t i, input bit fl);
    @(negedge clk);
    rst_n = !rst_req;
    id_valid = i.v; id_ctrl = i.c; id_rd = i.rd;
    id_rs1 = i.rs1; id_rs2 = i.rs2; id_use_rs1 = i.u1; id_use_rs2 = i.u2;
    ex_flush = fl;
    #1;
    check_all(i, fl);
    advance(i, fl);
  endtask

  task automatic zero_check(input string nm);
    chk({nm, "_stall"}, 32'(id_stall), 0);
    chk({nm, "_ex_valid"}, 32'(ex_valid), 0);
    chk({nm, "_ex_ctrl"}, 32'(ex_ctrl), 0);
    chk({nm, "_fpu_done"}, 32'(ex_fpu_done), 0);
    chk({nm, "_mem_valid"}, 32'(mem_valid), 0);
    chk({nm, "_wb_valid"}, 32'(wb_valid), 0);
    chk({nm, "_wb_rd"}, 32'(wb_rd), 0);
    chk({nm, "_gpr_we"}, 32'(wb_gpr_we), 0);
    chk({nm, "_fpr_we"}, 32'(wb_fpr_we), 0);
    chk({nm, "_fwd"}, 32'({fwd_a, fwd_b}), 0);
  endtask

  task automatic drain();
    for (int k = 0; k < 4; k++) cyc(bubble(), 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    ins_t nop, add3, sub4, lw5, add6, multf, rd0, rd0_use;
    int n, k;
    nop     = bubble();
    add3    = op(mk(2'b01, 1, 0, 0), 3, 1, 2, 1, 1);
    sub4    = op(mk(2'b01, 1, 0, 0), 4, 3, 1, 1, 1);
    lw5     = op(mk(2'b11, 1, 0, 0), 5, 1, 0, 1, 0);
    add6    = op(mk(2'b01, 1, 0, 0), 6, 5, 0, 1, 1);
    multf   = op(mk(2'b10, 1, 1, 1), 2, 4, 6, 1, 1);
    rd0     = op(mk(2'b01, 1, 0, 0), 0, 1, 2, 1, 1);
    rd0_use = op(mk(2'b01, 1, 0, 0), 7, 0, 0, 1, 1);
    model_reset();
    rst_n = 1'b0;

    // Reset held with live inputs: everything must read 0
    rst_req = 1'b1;
    for (int r = 0; r < 3; r++) cyc(add3, 1'b0);
    zero_check("reset");
    rst_req = 1'b0;

    // ADD r3 reaches WB exactly three cycles after issue
    cyc(add3, 1'b0);
    chk("add_issue_stall", 32'(id_stall), 0);
    cyc(nop, 1'b0);
    cyc(nop, 1'b0);
    chk("add_wb_early", 32'(wb_valid), 0);
    cyc(nop, 1'b0);
    chk("add_wb_valid", 32'(wb_valid), 1);
    chk("add_wb_gpr_we", 32'(wb_gpr_we), 1);
    chk("add_wb_rd", 32'(wb_rd), 3);
    drain();

    // ADD r3 ; SUB r4,r3,r1
    cyc(add3, 1'b0);
    n = 0; k = 0;
    do begin cyc(sub4, 1'b0); k++; if (id_stall) n++; end while (id_stall && k < 10);
`ifdef CTRL_PIPE_FWD_EN
    chk("raw_stall_cycles", 32'(n), 0);
    cyc(nop, 1'b0);
    chk("raw_fwd_a", 32'(fwd_a), 1);
`else
    chk("raw_stall_cycles", 32'(n), 2);
    cyc(nop, 1'b0);
    chk("raw_sub_in_ex", 32'(ex_valid), 1);
    chk("raw_fwd_a", 32'(fwd_a), 0);
`endif
    drain();

    // LW r5 ; ADD r6,r5,r0
    cyc(lw5, 1'b0);
    n = 0; k = 0;
    do begin cyc(add6, 1'b0); k++; if (id_stall) n++; end while (id_stall && k < 10);
    cyc(nop, 1'b0);
`ifdef CTRL_PIPE_FWD_EN
    chk("lu_stall_cycles", 32'(n), 1);
    chk("lu_fwd_a", 32'(fwd_a), 2);
`else
    chk("lu_stall_cycles", 32'(n), 2);
    chk("lu_fwd_a", 32'(fwd_a), 0);
`endif
    drain();

    // MULTF f2: LAT-1 hold cycles, done on the next, FPR write two cycles after that
    cyc(multf, 1'b0);
    n = 0; k = 0;
    do begin cyc(nop, 1'b0); k++; if (id_stall) n++; end while (id_stall && k < 20);
    chk("fpu_stall_cycles", 32'(n), 3);
    chk("fpu_done", 32'(ex_fpu_done), 1);
    cyc(nop, 1'b0);
    chk("fpu_wb_early", 32'(wb_fpr_we), 0);
    cyc(nop, 1'b0);
    chk("fpu_wb_fpr_we", 32'(wb_fpr_we), 1);
    chk("fpu_wb_rd", 32'(wb_rd), 2);
    drain();

    // Flush coincident with a RAW stall
    cyc(add3, 1'b0);
    cyc(sub4, 1'b1);
    chk("flush_stall", 32'(id_stall), 0);
    cyc(nop, 1'b0);
    chk("flush_ex_valid", 32'(ex_valid), 0);
    cyc(nop, 1'b0);
    chk("flush_add_wb", 32'(wb_gpr_we), 1);
    cyc(nop, 1'b0);
    chk("flush_sub_wb", 32'({wb_valid, wb_gpr_we}), 0);
    drain();

    // Writes to r0 neither commit nor interlock
    cyc(rd0, 1'b0);
    cyc(rd0_use, 1'b0);
    chk("r0_no_stall", 32'(id_stall), 0);
    cyc(nop, 1'b0);
    cyc(nop, 1'b0);
    chk("r0_wb_valid", 32'(wb_valid), 1);
    chk("r0_gpr_we", 32'(wb_gpr_we), 0);
    drain();

    // Asynchronous reset in the middle of an FPU hold
    cyc(multf, 1'b0);
    cyc(nop, 1'b0);
    chk("async_pre_hold", 32'(id_stall), 1);
    #1 rst_n = 1'b0;
    #1 zero_check("async");
    model_reset();
    rst_req = 1'b1;
    cyc(nop, 1'b0);
    cyc(nop, 1'b0);
    rst_req = 1'b0;
    cyc(add3, 1'b0);
    chk("async_no_hold", 32'(id_stall), 0);
    cyc(nop, 1'b0);
    chk("async_loads", 32'(ex_valid), 1);
    drain();

    // Random traffic against the model
    for (int c = 0; c < 1500; c++) cyc(rnd(), ($urandom_range(0, 7) == 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
